// File: rtl/m65_slot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : m65_slot_pkg
// Purpose  : Shared definitions for the m65 bus-slot arbiter. Holds the FSM
//            state encoding, the requester index constants and the width of
//            the DMA burst counter.
// Revision : 1.0 - initial release
// ============================================================================
package m65_slot_pkg;

  // Requester bit positions within req/done/grant.
  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;

  // One-bit owner identifiers, used for last_owner and the picker result.
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  // Consecutive-DMA-grant counter width; DMA_BURST_MAX must fit (1..15).
  localparam int BURST_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN_CPU = 2'd1,
    ST_OWN_DMA = 2'd2
  } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/m65_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : m65_rr_pick
// Purpose  : Combinational winner selection between CPU and DMA.
//            A single requester always wins. On a tie the owner that did not
//            win last time is chosen, except that the CPU is forced once the
//            DMA has taken DMA_BURST_MAX consecutive grants.
// Ports    : req        in  [1:0]        bit0 CPU, bit1 DMA
//            last_owner in  1            previous grant owner (1 = DMA)
//            burst_cnt  in  [BURST_W-1:0] consecutive DMA grants
//            winner     out 1            selected owner (1 = DMA); CPU if no req
// Revision : 1.0 - initial release
// ============================================================================
module m65_rr_pick
  import m65_slot_pkg::*;
#(
  parameter int DMA_BURST_MAX = 4
) (
  input  logic [1:0]         req,
  input  logic               last_owner,
  input  logic [BURST_W-1:0] burst_cnt,
  output logic               winner
);

  localparam logic [BURST_W-1:0] C_BURST_MAX = BURST_W'(DMA_BURST_MAX);

  always_comb begin
    winner = OWNER_CPU;
    case (req)
      2'b10: winner = OWNER_DMA;
      2'b11: begin
        if (burst_cnt >= C_BURST_MAX) begin
          winner = OWNER_CPU;
        end else begin
          winner = ~last_owner;
        end
      end
      default: winner = OWNER_CPU;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/m65_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : m65_slot_arbiter
// Purpose  : Grants the bus slot to CPU or DMA. A slot is either a slot_step
//            pulse or any cycle in full_speed mode; one unused slot may be
//            remembered (pending) and spent later. The grant is held until
//            the owner pulses its done bit, and may hand over directly to the
//            next winner without an idle cycle.
// Ports    : clk         in  1       system clock, rising edge
//            reset_n     in  1       asynchronous active-low reset
//            slot_step   in  1       slot pulse from the pacing counter
//            full_speed  in  1       every cycle is a slot
//            req         in  [1:0]   requests, bit0 CPU, bit1 DMA
//            done        in  [1:0]   owner finished its bus cycle
//            grant       out [1:0]   one-hot or zero, decoded from state flops
//            busy        out 1       any grant held
//            slot_miss   out [MISS_W-1:0] saturating count of dropped slots
// Config   : M65_SLOT_MISS_CNT_EN - when defined the slot_miss counter is
//            built; otherwise slot_miss is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module m65_slot_arbiter
  import m65_slot_pkg::*;
#(
  parameter int DMA_BURST_MAX = 4,
  parameter int MISS_W        = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              slot_step,
  input  logic              full_speed,
  input  logic [1:0]        req,
  input  logic [1:0]        done,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [MISS_W-1:0] slot_miss
);

  slot_state_t        r_state;
  slot_state_t        w_state_nxt;
  logic               r_pending;
  logic               w_pending_nxt;
  logic               r_last_owner;
  logic [BURST_W-1:0] r_burst_cnt;

  logic               w_slot_now;
  logic               w_slot_avail;
  logic               w_owner_done;
  logic               w_issue;
  logic               w_winner;

  assign w_slot_now   = full_speed | slot_step;
  assign w_slot_avail = w_slot_now | r_pending;

  // A done pulse on a bit that is not currently granted is ignored.
  assign w_owner_done = ((r_state == ST_OWN_CPU) && done[REQ_CPU]) ||
                        ((r_state == ST_OWN_DMA) && done[REQ_DMA]);

  m65_rr_pick #(
    .DMA_BURST_MAX (DMA_BURST_MAX)
  ) u_rr_pick (
    .req        (req),
    .last_owner (r_last_owner),
    .burst_cnt  (r_burst_cnt),
    .winner     (w_winner)
  );

  // --------------------------------------------------------------------------
  // FSM next-state / pending logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_issue       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_slot_avail && (|req)) begin
          w_issue = 1'b1;
        end else if (w_slot_now) begin
          w_pending_nxt = 1'b1;
        end
      end
      ST_OWN_CPU, ST_OWN_DMA: begin
        if (w_owner_done) begin
          if (w_slot_avail && (|req)) begin
            w_issue = 1'b1;
          end else begin
            // An unclaimed slot arriving with done is remembered.
            w_state_nxt   = ST_IDLE;
            w_pending_nxt = r_pending | w_slot_now;
          end
        end else if (w_slot_now) begin
          w_pending_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // Issuing a grant always spends the slot, including a remembered one.
    if (w_issue) begin
      w_state_nxt   = (w_winner == OWNER_DMA) ? ST_OWN_DMA : ST_OWN_CPU;
      w_pending_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration history. last_owner resets to DMA so the CPU wins the first
  // tie. burst_cnt counts DMA grants taken while the CPU was also waiting;
  // a DMA grant with no CPU request, or any CPU grant, restarts it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_owner <= OWNER_DMA;
      r_burst_cnt  <= '0;
    end else if (w_issue) begin
      r_last_owner <= w_winner;
      if ((w_winner == OWNER_DMA) && req[REQ_CPU]) begin
        if (r_burst_cnt != '1) begin
          r_burst_cnt <= r_burst_cnt + 1'b1;
        end
      end else begin
        r_burst_cnt <= '0;
      end
    end
  end

  assign grant = {(r_state == ST_OWN_DMA), (r_state == ST_OWN_CPU)};
  assign busy  = |grant;

`ifdef M65_SLOT_MISS_CNT_EN
  // A slot is lost when one arrives during a held grant while another slot
  // is already remembered.
  logic              w_slot_lost;
  logic [MISS_W-1:0] r_slot_miss;

  assign w_slot_lost = (r_state != ST_IDLE) && !w_owner_done &&
                       w_slot_now && r_pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_miss <= '0;
    end else if (w_slot_lost && (r_slot_miss != '1)) begin
      r_slot_miss <= r_slot_miss + 1'b1;
    end
  end

  assign slot_miss = r_slot_miss;
`else
  assign slot_miss = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_m65_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_m65_slot_arbiter
// Purpose  : Self-checking bench for m65_slot_arbiter: directed scenarios
//            followed by randomized traffic compared against a behavioural
//            model of slot ownership. Honors M65_SLOT_MISS_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m65_slot_arbiter;

  localparam int DMA_BURST_MAX = 4;
  localparam int MISS_W        = 8;
  localparam int MISS_MAX      = (1 << MISS_W) - 1;
`ifdef M65_SLOT_MISS_CNT_EN
  localparam bit MISS_EN = 1'b1;
`else
  localparam bit MISS_EN = 1'b0;
`endif

  logic              clk        = 1'b0;
  logic              reset_n    = 1'b0;
  logic              slot_step  = 1'b0;
  logic              full_speed = 1'b0;
  logic [1:0]        req        = 2'b00;
  logic [1:0]        done       = 2'b00;
  logic [1:0]        grant;
  logic              busy;
  logic [MISS_W-1:0] slot_miss;

  always #5 clk = ~clk;

  m65_slot_arbiter #(
    .DMA_BURST_MAX (DMA_BURST_MAX),
    .MISS_W        (MISS_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .slot_step  (slot_step),
    .full_speed (full_speed),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .busy       (busy),
    .slot_miss  (slot_miss)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: owner -1 none / 0 CPU / 1 DMA.
  int m_owner;
  int m_last;
  int m_streak;
  int m_miss;
  bit m_pending;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int exp_grant();
    if (m_owner < 0) return 0;
    return (m_owner == 0) ? 1 : 2;
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_last    = 1;
    m_streak  = 0;
    m_miss    = 0;
    m_pending = 1'b0;
  endtask

  function automatic int pick(input logic [1:0] rq);
    if (rq == 2'b01) return 0;
    if (rq == 2'b10) return 1;
    if (m_streak >= DMA_BURST_MAX) return 0;
    return 1 - m_last;
  endfunction

  task automatic model_step(input logic [1:0] rq, input logic [1:0] dn,
                            input logic ss, input logic fs);
    bit slot_now, avail, fin;
    int w;
    slot_now = ss | fs;
    avail    = slot_now | m_pending;
    fin      = (m_owner >= 0) && dn[m_owner[0]];
    if (m_owner < 0 || fin) begin
      if (avail && rq != 2'b00) begin
        w         = pick(rq);
        m_streak  = (w == 1 && rq[0]) ? ((m_streak < 15) ? m_streak + 1 : 15) : 0;
        m_last    = w;
        m_owner   = w;
        m_pending = 1'b0;
      end else begin
        m_owner = -1;
        if (slot_now) m_pending = 1'b1;
      end
    end else if (slot_now) begin
      if (m_pending && MISS_EN && m_miss < MISS_MAX) m_miss++;
      m_pending = 1'b1;
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_grant"}, int'(grant), exp_grant());
    check({tag, "_busy"},  int'(busy),  (m_owner >= 0) ? 1 : 0);
    check({tag, "_miss"},  int'(slot_miss), m_miss);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [1:0] rq, input logic [1:0] dn,
                      input logic ss, input logic fs);
    req        = rq;
    done       = dn;
    slot_step  = ss;
    full_speed = fs;
    model_step(rq, dn, ss, fs);
    @(posedge clk);
    #1;
    check_outs("cyc");
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between clock edges; grant must drop at once.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outs("rst");
    req = 2'b00; done = 2'b00; slot_step = 1'b0; full_speed = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] seq [4];
    logic [1:0] rq, dn;
    logic       fs;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single CPU request, slot at cycle 10, done at cycle 14.
    for (int i = 1; i < 10; i++) step(2'b01, 2'b00, 1'b0, 1'b0);
    step(2'b01, 2'b00, 1'b1, 1'b0);
    check("r030_grant_on", int'(grant), 1);
    for (int i = 11; i < 14; i++) step(2'b01, 2'b00, 1'b0, 1'b0);
    step(2'b01, 2'b01, 1'b0, 1'b0);
    check("r030_grant_off", int'(grant), 0);

    // Full speed alternation with immediate done.
    do_reset();
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
    step(2'b11, 2'b00, 1'b0, 1'b1);
    check("r031_seq0", int'(grant), int'(seq[0]));
    for (int i = 1; i < 4; i++) begin
      step(2'b11, grant, 1'b0, 1'b1);
      check("r031_seq", int'(grant), int'(seq[i]));
    end

    // DMA alone on paced slots, then CPU joins.
    do_reset();
    for (int s = 0; s < 6; s++) begin
      step(2'b10, 2'b00, 1'b1, 1'b0);
      check("r032_dma", int'(grant), 2);
      step(2'b10, 2'b10, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) step(2'b10, 2'b00, 1'b0, 1'b0);
    end
    begin
      int cpu_at;
      cpu_at = -1;
      for (int s = 0; s < 5; s++) begin
        step(2'b11, 2'b00, 1'b1, 1'b0);
        if (cpu_at < 0 && grant == 2'b01) cpu_at = s;
        step(2'b11, grant, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(2'b11, 2'b00, 1'b0, 1'b0);
      end
      check("r032_cpu_wins", (cpu_at >= 0 && cpu_at < 5) ? 1 : 0, 1);
    end

    // DMA holds the bus through three slots.
    do_reset();
    step(2'b10, 2'b00, 1'b1, 1'b0);
    for (int s = 0; s < 3; s++) begin
      step(2'b10, 2'b00, 1'b0, 1'b0);
      step(2'b10, 2'b00, 1'b1, 1'b0);
    end
    check("r033_miss", int'(slot_miss), MISS_EN ? 2 : 0);
    check("r033_held", int'(grant), 2);

    // Miss counter saturation under full speed.
    for (int i = 0; i < 300; i++) step(2'b10, 2'b00, 1'b0, 1'b1);
    check("miss_sat", int'(slot_miss), MISS_EN ? MISS_MAX : 0);

    // Remembered slot consumed by a later request, then reset mid-grant.
    do_reset();
    for (int i = 1; i < 5; i++) step(2'b00, 2'b00, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b1, 1'b0);
    for (int i = 6; i < 8; i++) step(2'b00, 2'b00, 1'b0, 1'b0);
    step(2'b01, 2'b00, 1'b0, 1'b0);
    check("r034_pending_grant", int'(grant), 1);
    do_reset();
    check("r034_reset_grant", int'(grant), 0);

    // Randomized traffic.
    fs = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) fs = ~fs;
      rq = 2'($urandom_range(0, 3));
      dn = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      step(rq, dn, ($urandom_range(0, 3) == 0), fs);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
